// File: rtl/lcd_pkg.sv
// Shared constants and types for the character-LCD refresh controller:
// HD44780 command bytes, DDRAM row base addresses and FSM/phase encodings.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_2L = 8'h38;
  localparam logic [7:0] FUNC_SET_1L = 8'h30;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] ENTRY_INC   = 8'h06;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] SET_DDRAM   = 8'h80;

  localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;
  typedef enum logic [1:0] {ST_POWER, ST_INIT, ST_REFRESH, ST_IDLE} state_t;

  function automatic logic [7:0] row_addr_cmd(input logic [1:0] r);
    return SET_DDRAM | ROW_BASE[r];
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx, input logic one_line);
    case (idx)
      2'd0:    return one_line ? FUNC_SET_1L : FUNC_SET_2L;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_INC;
      default: return CLEAR;
    endcase
  endfunction

  function automatic int max_of5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD bus write: SETUP (EN low), PULSE (EN high), HOLD (EN low, long after CLEAR).
// RS/DATA are latched at start and stay constant until the next start.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int CNT_W       = 17,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 25,
  parameter int T_CMD_CYC   = 2500,
  parameter int T_CLEAR_CYC = 100000
) (
  input  logic       clock,
  input  logic       sync_rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] bus_byte,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  phase_t           phase;
  logic             busy;
  logic             long_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_last;

  assign hold_last = long_r ? CNT_W'(T_CLEAR_CYC - 1) : CNT_W'(T_CMD_CYC - 1);
  // A start is accepted on the DONE cycle so back-to-back bytes have no gap.
  assign done      = busy && (phase == PH_HOLD) && (cnt == hold_last);

  always_ff @(posedge clock) begin
    if (sync_rst) begin
      busy     <= 1'b0;
      phase    <= PH_SETUP;
      cnt      <= '0;
      long_r   <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (start && (!busy || done)) begin
      busy     <= 1'b1;
      phase    <= PH_SETUP;
      cnt      <= '0;
      long_r   <= long_wait;
      lcd_en   <= 1'b0;
      lcd_rs   <= rs;
      lcd_data <= bus_byte;
    end else if (busy) begin
      case (phase)
        PH_SETUP: begin
          if (cnt == CNT_W'(T_SETUP_CYC - 1)) begin
            phase  <= PH_PULSE;
            cnt    <= '0;
            lcd_en <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PH_PULSE: begin
          if (cnt == CNT_W'(T_EN_CYC - 1)) begin
            phase  <= PH_HOLD;
            cnt    <= '0;
            lcd_en <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PH_HOLD: begin
          if (cnt == hold_last) begin
            busy <= 1'b0;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: phase <= PH_SETUP;
      endcase
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// HD44780-class LCD controller: power-on wait, init commands, then full-frame
// refreshes on a REQ/READY handshake with a one-deep pending request.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS        = 2,
  parameter int COLS        = 16,
  parameter int T_POWER_CYC = 750000,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 25,
  parameter int T_CMD_CYC   = 2500,
  parameter int T_CLEAR_CYC = 100000
) (
  input  logic                   clock,
  input  logic                   sync_rst,
  input  logic [ROWS*COLS*8-1:0] data,
  input  logic                   req,
  output logic                   ready,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_en,
  output logic [7:0]             lcd_data
);

  localparam int FRAME_W = ROWS * COLS * 8;
  localparam int CNT_W   = $clog2(max_of5(T_POWER_CYC, T_SETUP_CYC, T_EN_CYC,
                                          T_CMD_CYC, T_CLEAR_CYC) + 1);
  localparam int RW      = $clog2(ROWS) + 1;
  localparam int CW      = $clog2(COLS) + 1;
  localparam logic [RW-1:0]    ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
  localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(T_POWER_CYC - 1);
  localparam logic             ONE_LINE = (ROWS == 1);

  if (!(ROWS == 1 || ROWS == 2 || ROWS == 4)) begin : g_rows_illegal
    $error("lcd_refresh_ctrl: ROWS must be 1, 2 or 4");
  end
  if (COLS < 1 || COLS > 40) begin : g_cols_illegal
    $error("lcd_refresh_ctrl: COLS must be 1..40");
  end

  state_t           state;
  logic [CNT_W-1:0] pw_cnt;
  logic [1:0]       init_idx;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic             in_addr;
  logic             pending;
  logic [FRAME_W-1:0] snap;

  logic       wr_start;
  logic       wr_rs;
  logic [7:0] wr_byte;
  logic       wr_long;
  logic       wr_done;
  logic       snap_load;

  function automatic logic [7:0] snap_char(input int r, input int c);
    logic [FRAME_W-1:0] t;
    t = snap << (8 * (r * COLS + c));
    return t[FRAME_W-1 -: 8];
  endfunction

  // Next byte is chosen in the cycle the previous one finishes, so writes run back to back.
  always_comb begin
    wr_start  = 1'b0;
    wr_rs     = 1'b0;
    wr_byte   = 8'h00;
    snap_load = 1'b0;
    case (state)
      ST_POWER: begin
        if (pw_cnt == PW_LAST) begin
          wr_start = 1'b1;
          wr_byte  = init_cmd(2'd0, ONE_LINE);
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (init_idx == 2'd3) begin
            wr_byte   = row_addr_cmd(2'd0);
            snap_load = 1'b1;
          end else begin
            wr_byte = init_cmd(init_idx + 2'd1, ONE_LINE);
          end
        end
      end
      ST_REFRESH: begin
        if (wr_done) begin
          if (in_addr) begin
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_byte  = snap_char(int'(row), 0);
          end else if (col != COL_LAST) begin
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_byte  = snap_char(int'(row), int'(col) + 1);
          end else if (row != ROW_LAST) begin
            wr_start = 1'b1;
            wr_byte  = row_addr_cmd(2'(row + RW'(1)));
          end else if (pending || req) begin
            wr_start  = 1'b1;
            wr_byte   = row_addr_cmd(2'd0);
            snap_load = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (req) begin
          wr_start  = 1'b1;
          wr_byte   = row_addr_cmd(2'd0);
          snap_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign wr_long = !wr_rs && (wr_byte == CLEAR);
  assign lcd_rw  = 1'b0;

  always_ff @(posedge clock) begin
    if (sync_rst) begin
      state    <= ST_POWER;
      pw_cnt   <= '0;
      init_idx <= 2'd0;
      row      <= '0;
      col      <= '0;
      in_addr  <= 1'b0;
      pending  <= 1'b0;
      ready    <= 1'b0;
    end else begin
      if (req && state != ST_IDLE) pending <= 1'b1;
      case (state)
        ST_POWER: begin
          if (wr_start) state <= ST_INIT;
          else          pw_cnt <= pw_cnt + CNT_W'(1);
        end
        ST_INIT: begin
          if (wr_done) begin
            if (init_idx == 2'd3) begin
              state   <= ST_REFRESH;
              row     <= '0;
              col     <= '0;
              in_addr <= 1'b1;
            end else begin
              init_idx <= init_idx + 2'd1;
            end
          end
        end
        ST_REFRESH: begin
          if (wr_done) begin
            if (in_addr) begin
              in_addr <= 1'b0;
              col     <= '0;
            end else if (col != COL_LAST) begin
              col <= col + CW'(1);
            end else if (row != ROW_LAST) begin
              row     <= row + RW'(1);
              col     <= '0;
              in_addr <= 1'b1;
            end else begin
              // Frame end: a pending or simultaneous request chains straight into a new frame.
              row     <= '0;
              col     <= '0;
              pending <= 1'b0;
              if (pending || req) begin
                in_addr <= 1'b1;
              end else begin
                state <= ST_IDLE;
                ready <= 1'b1;
              end
            end
          end
        end
        ST_IDLE: begin
          if (req) begin
            state   <= ST_REFRESH;
            ready   <= 1'b0;
            row     <= '0;
            col     <= '0;
            in_addr <= 1'b1;
          end
        end
        default: state <= ST_POWER;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (snap_load) snap <= data;
  end

  lcd_byte_writer #(
    .CNT_W      (CNT_W),
    .T_SETUP_CYC(T_SETUP_CYC),
    .T_EN_CYC   (T_EN_CYC),
    .T_CMD_CYC  (T_CMD_CYC),
    .T_CLEAR_CYC(T_CLEAR_CYC)
  ) u_writer (
    .clock    (clock),
    .sync_rst (sync_rst),
    .start    (wr_start),
    .rs       (wr_rs),
    .bus_byte (wr_byte),
    .long_wait(wr_long),
    .done     (wr_done),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

endmodule
